fft_src_ctrl: RTL and testbench

FFT_SRC_CTRL -- requirements
Module: fft_src_ctrl

---
 rtl/fft_src_pkg.sv | 24 ++
 rtl/fft_src_fifo2.sv | 53 +++++
 rtl/fft_src_ctrl.sv | 129 ++++++++++++
 tb/tb_fft_src_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_src_pkg.sv
// Shared types and helpers for the FFT sample source controller.
package fft_src_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

    localparam int unsigned FIFO_DEPTH = 2;

    // Reverses the low nbits of value; bits at and above nbits come back as 0.
    function automatic logic [31:0] bit_reverse(input logic [31:0] value, input int unsigned nbits);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < nbits) begin
                r[i] = value[nbits - 1 - i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_src_fifo2.sv
// Two-entry output FIFO carrying a sample plus its frame start/end tags.
module fft_src_fifo2
    import fft_src_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              din_sop,
    input  logic              din_eop,
    input  logic              pop,
    output logic              valid,
    output logic [DATA_W-1:0] dout,
    output logic              dout_sop,
    output logic              dout_eop,
    output logic [1:0]        count
);

    logic [DATA_W+1:0] mem [FIFO_DEPTH];
    // With two entries each pointer is a single toggling bit.
    logic              wr_ptr;
    logic              rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {din_sop, din_eop, din};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign {dout_sop, dout_eop, dout} = mem[rd_ptr];
    assign valid = (count != 2'd0);

endmodule

// File: rtl/fft_src_ctrl.sv
// Streams frames of samples from a ROM to an FFT input with ready/valid flow control.
// Optional bit-reversed addressing is built only when FFT_SRC_CTRL_BITREV_EN is defined.
module fft_src_ctrl
    import fft_src_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned FRAME_LEN = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cont,
    input  logic              stop,
    input  logic              cfg_bitrev,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_ad,
    input  logic [DATA_W-1:0] rom_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_sop,
    output logic              m_eop,
    output logic              busy,
    output logic              done
);

    localparam int unsigned       IDX_BITS = $clog2(FRAME_LEN);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] index;
    logic              cont_q;
    logic              inflight;
    logic              inflight_sop;
    logic              inflight_eop;
    logic              pop;
    logic [1:0]        count;
    logic [2:0]        level;
    logic              space;
    logic              drain_empty;

    // Occupancy the FIFO will have after this cycle's in-flight push and pop.
    assign pop         = m_valid & m_ready;
    assign level       = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    assign space       = (level < 3'd2);
    assign drain_empty = !inflight && (level == 3'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (start) state_next = FETCH;
            FETCH: if (rom_ce && (index == LAST_IDX) && (!cont_q || stop)) state_next = DRAIN;
            DRAIN: if (drain_empty) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rom_ce = (state == FETCH) && space;
        busy   = (state != IDLE);
        done   = (state == DRAIN) && drain_empty;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index        <= '0;
            cont_q       <= 1'b0;
            inflight     <= 1'b0;
            inflight_sop <= 1'b0;
            inflight_eop <= 1'b0;
        end else begin
            inflight     <= rom_ce;
            inflight_sop <= rom_ce && (index == '0);
            inflight_eop <= rom_ce && (index == LAST_IDX);
            if (state == IDLE && start) begin
                cont_q <= cont;
                index  <= '0;
            end else if (rom_ce) begin
                index <= (index == LAST_IDX) ? '0 : index + ADDR_W'(1);
            end
        end
    end

`ifdef FFT_SRC_CTRL_BITREV_EN
    logic bitrev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bitrev_q <= 1'b0;
        end else if (state == IDLE && start) begin
            bitrev_q <= cfg_bitrev;
        end
    end

    assign rom_ad = bitrev_q ? ADDR_W'(bit_reverse(32'(index), IDX_BITS)) : index;
`else
    logic unused_cfg_bitrev;
    assign unused_cfg_bitrev = cfg_bitrev;
    assign rom_ad = index;
`endif

    fft_src_fifo2 #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight),
        .din      (rom_dout),
        .din_sop  (inflight_sop),
        .din_eop  (inflight_eop),
        .pop      (pop),
        .valid    (m_valid),
        .dout     (m_data),
        .dout_sop (m_sop),
        .dout_eop (m_eop),
        .count    (count)
    );

endmodule

// File: tb/tb_fft_src_ctrl.sv
// Directed bench for fft_src_ctrl: a 1024-sample instance plus an 8-sample instance for address order.
module tb_fft_src_ctrl;

    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 16;
    localparam int FRAME_LEN = 1024;

    logic              clk = 1'b0;
    logic              rst, start, cont, stop, cfg_bitrev, m_ready;
    logic              rom_ce, m_valid, m_sop, m_eop, busy, done;
    logic [ADDR_W-1:0] rom_ad;
    logic [DATA_W-1:0] rom_dout, m_data;

    logic              s_start, s_rom_ce, s_m_valid, s_m_sop, s_m_eop, s_busy, s_done;
    logic [2:0]        s_rom_ad;
    logic [DATA_W-1:0] s_rom_dout, s_m_data;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Ramp ROMs: data = address, one cycle after the read enable.
    always @(posedge clk) if (rom_ce) rom_dout <= DATA_W'(rom_ad);
    always @(posedge clk) if (s_rom_ce) s_rom_dout <= DATA_W'(s_rom_ad);

    fft_src_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN)) dut (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .stop(stop), .cfg_bitrev(cfg_bitrev),
        .rom_ce(rom_ce), .rom_ad(rom_ad), .rom_dout(rom_dout),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sop(m_sop), .m_eop(m_eop),
        .busy(busy), .done(done)
    );

    fft_src_ctrl #(.ADDR_W(3), .DATA_W(DATA_W), .FRAME_LEN(8)) dut8 (
        .clk(clk), .rst(rst), .start(s_start), .cont(cont), .stop(stop), .cfg_bitrev(cfg_bitrev),
        .rom_ce(s_rom_ce), .rom_ad(s_rom_ad), .rom_dout(s_rom_dout),
        .m_valid(s_m_valid), .m_ready(m_ready), .m_data(s_m_data), .m_sop(s_m_sop), .m_eop(s_m_eop),
        .busy(s_busy), .done(s_done)
    );

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; cont = 1'b0; stop = 1'b0; cfg_bitrev = 1'b0;
        m_ready = 1'b1; s_start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (rom_ce !== 1'b0 || rom_ad !== '0) begin
            miscompares++; $display("FAIL reset_rom: rom_ce=%b rom_ad=%0d expected 0/0", rom_ce, rom_ad);
        end
        vectors++;
        if ({m_valid, m_sop, m_eop} !== 3'b000 || m_data !== '0) begin
            miscompares++;
            $display("FAIL reset_stream: valid/sop/eop=%b data=%0h expected 000/0", {m_valid, m_sop, m_eop}, m_data);
        end
        vectors++;
        if ({busy, done, s_busy, s_done, s_rom_ce} !== 5'b0) begin
            miscompares++; $display("FAIL reset_status: busy/done/s_busy/s_done/s_ce=%b expected 00000", {busy, done, s_busy, s_done, s_rom_ce});
        end
        @(negedge clk); rst = 1'b0; stop = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0 || rom_ce !== 1'b0) begin
            miscompares++; $display("FAIL stop_in_idle: busy=%b rom_ce=%b expected 0/0", busy, rom_ce);
        end
        stop = 1'b0;
    endtask

    task automatic test_single_frame();
        int n = 0, done_cnt = 0, done_cyc = -1;
        @(negedge clk); start = 1'b1; cont = 1'b0; m_ready = 1'b1; #1;
        for (int k = 1; k <= 1030; k++) begin
            @(negedge clk); start = 1'b0; #1;
            if (k == 1) begin
                vectors++;
                if (rom_ce !== 1'b1 || rom_ad !== '0) begin
                    miscompares++; $display("FAIL first_issue: rom_ce=%b rom_ad=%0d expected 1/0", rom_ce, rom_ad);
                end
            end
            if (k == 3) begin
                vectors++;
                if (m_valid !== 1'b1 || m_data !== '0 || m_sop !== 1'b1) begin
                    miscompares++; $display("FAIL first_sample: valid=%b data=%0d sop=%b expected 1/0/1", m_valid, m_data, m_sop);
                end
            end
            if (m_valid && m_ready) begin
                vectors++;
                if (m_data !== DATA_W'(n) || m_sop !== (n == 0) || m_eop !== (n == FRAME_LEN - 1)) begin
                    miscompares++;
                    $display("FAIL single_sample: data=%0d sop=%b eop=%b expected %0d/%b/%b", m_data, m_sop, m_eop, n, n == 0, n == FRAME_LEN - 1);
                end
                n++;
            end
            if (done === 1'b1) begin done_cnt++; done_cyc = k; end
        end
        vectors++;
        if (n != FRAME_LEN || done_cnt != 1 || done_cyc != 1026) begin
            miscompares++; $display("FAIL single_totals: samples=%0d dones=%0d done_cycle=%0d expected 1024/1/1026", n, done_cnt, done_cyc);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++; $display("FAIL single_idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_backpressure();
        int n = 0, occ = 0, infl = 0, pop = 0, done_cnt = 0;
        logic prev_stall = 1'b0;
        logic [DATA_W+1:0] prev = '0;
        @(negedge clk); start = 1'b1; cont = 1'b0; m_ready = 1'b1; #1;
        for (int k = 1; k <= 2500 && done_cnt == 0; k++) begin
            @(negedge clk); start = 1'b0;
            if (k >= 3 && k <= 6) m_ready = (k % 2 == 1);
            else if (k >= 7 && k <= 26) m_ready = 1'($urandom_range(0, 1));
            else m_ready = 1'b1;
            #1;
            pop = (m_valid && m_ready) ? 1 : 0;
            vectors++;
            if (m_valid !== (occ > 0)) begin
                miscompares++; $display("FAIL bp_valid: cycle %0d m_valid=%b expected %b", k, m_valid, occ > 0);
            end
            if (occ + infl - pop >= 2) begin
                vectors++;
                if (rom_ce !== 1'b0) begin
                    miscompares++; $display("FAIL bp_full_ce: cycle %0d rom_ce=%b expected 0", k, rom_ce);
                end
            end
            if (prev_stall) begin
                vectors++;
                if (m_valid !== 1'b1 || {m_data, m_sop, m_eop} !== prev) begin
                    miscompares++; $display("FAIL bp_hold: cycle %0d valid=%b word=%0h expected 1/%0h", k, m_valid, {m_data, m_sop, m_eop}, prev);
                end
            end
            if (pop == 1) begin
                vectors++;
                if (m_data !== DATA_W'(n) || m_sop !== (n == 0) || m_eop !== (n == FRAME_LEN - 1)) begin
                    miscompares++; $display("FAIL bp_sample: data=%0d sop=%b eop=%b expected %0d", m_data, m_sop, m_eop, n);
                end
                n++;
            end
            if (done === 1'b1) done_cnt++;
            prev_stall = m_valid && !m_ready;
            prev = {m_data, m_sop, m_eop};
            occ = occ + infl - pop;
            infl = rom_ce ? 1 : 0;
        end
        @(negedge clk); #1;
        vectors++;
        if (n != FRAME_LEN || done_cnt != 1 || busy !== 1'b0) begin
            miscompares++; $display("FAIL bp_totals: samples=%0d dones=%0d busy=%b expected 1024/1/0", n, done_cnt, busy);
        end
    endtask

    task automatic test_continuous();
        int n = 0, sops = 0, eops = 0, done_cnt = 0;
        @(negedge clk); start = 1'b1; cont = 1'b1; m_ready = 1'b1; #1;
        for (int k = 1; k <= 2300 && done_cnt == 0; k++) begin
            @(negedge clk); start = 1'b0;
            if (n >= 1500) stop = 1'b1;
            #1;
            if (m_valid && m_ready) begin
                vectors++;
                if (m_data !== DATA_W'(n % FRAME_LEN) || m_sop !== (n % FRAME_LEN == 0)) begin
                    miscompares++; $display("FAIL cont_sample: data=%0d sop=%b expected %0d", m_data, m_sop, n % FRAME_LEN);
                end
                sops += m_sop ? 1 : 0;
                eops += m_eop ? 1 : 0;
                n++;
            end
            if (done === 1'b1) done_cnt++;
        end
        repeat (4) begin
            @(negedge clk); #1;
            if (done === 1'b1) done_cnt++;
        end
        stop = 1'b0; cont = 1'b0;
        vectors++;
        if (n != 2 * FRAME_LEN || sops != 2 || eops != 2 || done_cnt != 1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL cont_totals: samples=%0d sops=%0d eops=%0d dones=%0d busy=%b expected 2048/2/2/1/0", n, sops, eops, done_cnt, busy);
        end
    endtask

    task automatic test_stop_at_last();
        int n = 0, done_cnt = 0;
        logic stopped = 1'b0;
        @(negedge clk); start = 1'b1; cont = 1'b1; m_ready = 1'b1; #1;
        for (int k = 1; k <= 1100; k++) begin
            @(negedge clk); start = 1'b0; stop = 1'b0; #1;
            if (!stopped && rom_ce && rom_ad == ADDR_W'(FRAME_LEN - 1)) begin
                stop = 1'b1; stopped = 1'b1;
            end
            if (m_valid && m_ready) n++;
            if (done === 1'b1) done_cnt++;
        end
        stop = 1'b0; cont = 1'b0;
        vectors++;
        if (n != FRAME_LEN || done_cnt != 1 || busy !== 1'b0) begin
            miscompares++; $display("FAIL stop_at_last: samples=%0d dones=%0d busy=%b expected 1024/1/0", n, done_cnt, busy);
        end
    endtask

    task automatic test_addr_order();
        int exp_ad[8];
        int issued = 0, popped = 0, done_cnt = 0;
`ifdef FFT_SRC_CTRL_BITREV_EN
        exp_ad = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
        exp_ad = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
        @(negedge clk); s_start = 1'b1; cfg_bitrev = 1'b1; cont = 1'b0; m_ready = 1'b1; #1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk); s_start = 1'b0; cfg_bitrev = 1'b0; #1;
            if (s_rom_ce) begin
                vectors++;
                if (issued >= 8 || s_rom_ad !== 3'(exp_ad[issued])) begin
                    miscompares++; $display("FAIL order_addr: issue %0d rom_ad=%0d expected %0d", issued, s_rom_ad, exp_ad[issued % 8]);
                end
                issued++;
            end
            if (s_m_valid && m_ready) begin
                vectors++;
                if (popped >= 8 || s_m_data !== DATA_W'(exp_ad[popped]) || s_m_sop !== (popped == 0) || s_m_eop !== (popped == 7)) begin
                    miscompares++; $display("FAIL order_data: pop %0d data=%0d expected %0d", popped, s_m_data, exp_ad[popped % 8]);
                end
                popped++;
            end
            if (s_done === 1'b1) done_cnt++;
        end
        vectors++;
        if (issued != 8 || popped != 8 || done_cnt != 1 || s_busy !== 1'b0) begin
            miscompares++; $display("FAIL order_totals: issued=%0d popped=%0d dones=%0d busy=%b expected 8/8/1/0", issued, popped, done_cnt, s_busy);
        end
    endtask

    task automatic test_reset_midrun();
        int n = 0, done_cnt = 0, done_cyc = -1;
        @(negedge clk); start = 1'b1; cont = 1'b0; m_ready = 1'b1; #1;
        for (int k = 1; k <= 600 && n < 500; k++) begin
            @(negedge clk); start = 1'b0; #1;
            if (m_valid && m_ready) n++;
            if (done === 1'b1) done_cnt++;
        end
        @(negedge clk); rst = 1'b1; #1;
        vectors++;
        if ({rom_ce, m_valid, m_sop, m_eop, busy, done} !== 6'b0 || rom_ad !== '0 || m_data !== '0) begin
            miscompares++;
            $display("FAIL midrun_reset_outputs: ce/valid/sop/eop/busy/done=%b ad=%0d data=%0d expected all 0", {rom_ce, m_valid, m_sop, m_eop, busy, done}, rom_ad, m_data);
        end
        @(negedge clk); #1;
        if (done === 1'b1) done_cnt++;
        @(negedge clk); rst = 1'b0; #1;
        if (done === 1'b1) done_cnt++;
        vectors++;
        if (n != 500 || done_cnt != 0) begin
            miscompares++; $display("FAIL midrun_before_restart: samples=%0d dones=%0d expected 500/0", n, done_cnt);
        end
        n = 0;
        @(negedge clk); start = 1'b1; #1;
        for (int k = 1; k <= 1030; k++) begin
            @(negedge clk); start = 1'b0; #1;
            if (k == 1) begin
                vectors++;
                if (rom_ce !== 1'b1 || rom_ad !== '0) begin
                    miscompares++; $display("FAIL restart_issue: rom_ce=%b rom_ad=%0d expected 1/0", rom_ce, rom_ad);
                end
            end
            if (m_valid && m_ready) begin
                vectors++;
                if (m_data !== DATA_W'(n) || m_sop !== (n == 0)) begin
                    miscompares++; $display("FAIL restart_sample: data=%0d sop=%b expected %0d", m_data, m_sop, n);
                end
                n++;
            end
            if (done === 1'b1) begin done_cnt++; done_cyc = k; end
        end
        vectors++;
        if (n != FRAME_LEN || done_cnt != 1 || done_cyc != 1026) begin
            miscompares++; $display("FAIL restart_totals: samples=%0d dones=%0d done_cycle=%0d expected 1024/1/1026", n, done_cnt, done_cyc);
        end
    endtask

    task automatic test_start_while_busy();
        int n = 0, done_cnt = 0, done_cyc = -1, ce_after = 0;
        @(negedge clk); start = 1'b1; cont = 1'b0; m_ready = 1'b1; #1;
        for (int k = 1; k <= 1036; k++) begin
            @(negedge clk);
            start = (k == 100 || k == 600 || k == 1025) ? 1'b1 : 1'b0;
            #1;
            if (m_valid && m_ready) begin
                vectors++;
                if (m_data !== DATA_W'(n)) begin
                    miscompares++; $display("FAIL busy_start_sample: data=%0d expected %0d", m_data, n);
                end
                n++;
            end
            if (done === 1'b1) begin done_cnt++; done_cyc = k; end
            if (k > 1026 && rom_ce === 1'b1) ce_after++;
        end
        start = 1'b0;
        vectors++;
        if (n != FRAME_LEN || done_cnt != 1 || done_cyc != 1026 || ce_after != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_start_totals: samples=%0d dones=%0d done_cycle=%0d late_reads=%0d busy=%b expected 1024/1/1026/0/0", n, done_cnt, done_cyc, ce_after, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_continuous();
        test_stop_at_last();
        test_addr_order();
        test_reset_midrun();
        test_start_while_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
